// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_types
//   Shared types for the pipeline hazard controller.
//   fetch_state_t : fetch-side FSM states
//                   F_RUN    - normal fetch
//                   F_HOLD   - an I-mem response arrived while the front end
//                              was held, and the word is kept in IF
//                   F_SQUASH - the next I-mem response belongs to a stale PC
//   LU_CNT_W      : width of the load-use bubble counter (LOAD_BUBBLES <= 3)
// ---------------------------------------------------------------------------
package hazard_types;

    typedef enum logic [1:0] {
        F_RUN    = 2'd0,
        F_HOLD   = 2'd1,
        F_SQUASH = 2'd2
    } fetch_state_t;

    localparam int LU_CNT_W = 2;

endpackage : hazard_types

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// ---------------------------------------------------------------------------
// hazard_perf_cnt
//   Saturating event counter. Priority: rst > clr > inc. The counter holds
//   at all-ones and does not wrap.
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset
//   clr   in  synchronous clear
//   inc   in  count one event this cycle
//   count out current count
// ---------------------------------------------------------------------------
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule : hazard_perf_cnt

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush controller for a 5-stage RV32I pipeline. It resolves, in
//   priority order, D-mem back-pressure, EX redirects, load-use hazards and
//   I-mem latency. A small fetch FSM keeps an early I-mem word and discards
//   the stale response after a redirect. All decisions are combinational
//   from inputs and registered state.
//   Inputs : clk, rst (sync, active high), imem_resp, dmem_req_mem, dmem_resp,
//            rs1_id, rs2_id, rs1_used_id, rs2_used_id, ex_valid, ex_is_load,
//            rd_ex, redirect_ex, clr_cnt
//   Outputs: pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
//            idex_flush, fetch_hold, fetch_squash,
//            cnt_imem_stall, cnt_dmem_stall, cnt_load_use, cnt_redirect
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import hazard_types::*;
#(
    parameter int REG_W        = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_req_mem,
    input  logic             dmem_resp,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             redirect_ex,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             fetch_hold,
    output logic             fetch_squash,
    output logic [CNT_W-1:0] cnt_imem_stall,
    output logic [CNT_W-1:0] cnt_dmem_stall,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_redirect
);

    fetch_state_t        state_q, state_d;
    logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;

    logic adv, fetch_ok, lu_hit, lu_idle, lu_stall;

    // The whole back end advances unless MEM waits on D-mem.
    assign adv      = ~(dmem_req_mem & ~dmem_resp);
    assign fetch_ok = ((state_q == F_RUN) & imem_resp) | (state_q == F_HOLD);
    assign lu_idle  = (lu_cnt_q == '0);

    // x0 is never a real producer, and only sources the ID instruction
    // actually reads can create a hazard.
    assign lu_hit = ex_valid & ex_is_load & (rd_ex != '0) &
                    ((rs1_used_id & (rs1_id == rd_ex)) |
                     (rs2_used_id & (rs2_id == rd_ex)));

    // The first bubble comes from the live hit; any further bubbles are
    // driven by the counter after the load has left EX.
    assign lu_stall = (lu_hit & lu_idle) | ~lu_idle;

    // NOTE: every output gets a default before the branches, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        idex_en    = 1'b0;
        if (!rst && adv) begin
            idex_en = 1'b1;
            if (redirect_ex) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_stall) begin
                idex_flush = 1'b1;
            end else if (fetch_ok) begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end else begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
            end
        end
    end

    assign exmem_en     = idex_en;
    assign memwb_en     = idex_en;
    assign fetch_hold   = ~rst & (state_q == F_HOLD);
    assign fetch_squash = ~rst & (state_q == F_SQUASH);

    // Load-use bubble counter. A taken redirect flushes the consumer, so any
    // pending bubbles are dropped.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (adv) begin
            if (redirect_ex) begin
                lu_cnt_d = '0;
            end else if (!lu_idle) begin
                lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
            end else if (lu_hit) begin
                lu_cnt_d = LU_CNT_W'(LOAD_BUBBLES - 1);
            end
        end
    end

    // Fetch FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_RUN: begin
                if (!adv) begin
                    // Keep a response that arrives while the pipe is frozen.
                    if (imem_resp) state_d = F_HOLD;
                end else if (redirect_ex) begin
                    // A request to the old PC is still outstanding.
                    if (!imem_resp) state_d = F_SQUASH;
                end else if (lu_stall) begin
                    if (imem_resp) state_d = F_HOLD;
                end
            end
            F_HOLD: begin
                // The held word is consumed on a normal advance and dropped
                // on a redirect; either way fetch resumes.
                if (adv && (redirect_ex || !lu_stall)) state_d = F_RUN;
            end
            F_SQUASH: begin
                if (imem_resp && !(adv && redirect_ex)) state_d = F_RUN;
            end
            default: state_d = F_RUN;
        endcase
    end

    // NOTE: only control state is reset here; this block holds no memories
    // that would need (or should get) a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= F_RUN;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Performance counters.
    logic inc_imem, inc_dmem, inc_lu, inc_redir;

    assign inc_imem  = adv & ~fetch_ok & ~lu_stall & ~redirect_ex;
    assign inc_dmem  = ~adv;
    assign inc_lu    = adv & lu_hit & lu_idle & ~redirect_ex;
    assign inc_redir = adv & redirect_ex;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_imem (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(inc_imem), .count(cnt_imem_stall)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_dmem (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(inc_dmem), .count(cnt_dmem_stall)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_lu (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(inc_lu), .count(cnt_load_use)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_redir (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(inc_redir), .count(cnt_redirect)
    );

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Two controllers share one stimulus: dut (LOAD_BUBBLES=1, CNT_W=32) and
//   dut3 (LOAD_BUBBLES=3, CNT_W=4). Inputs change just after the falling
//   edge; outputs are sampled 1 ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_resp, dmem_req_mem, dmem_resp;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_used_id, rs2_used_id, ex_valid, ex_is_load;
    logic       redirect_ex, clr_cnt;

    logic        a_pc_en, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en;
    logic        a_ifid_flush, a_idex_flush, a_fetch_hold, a_fetch_squash;
    logic [31:0] a_cnt_imem, a_cnt_dmem, a_cnt_lu, a_cnt_redir;

    logic        b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en;
    logic        b_ifid_flush, b_idex_flush, b_fetch_hold, b_fetch_squash;
    logic [3:0]  b_cnt_imem, b_cnt_dmem, b_cnt_lu, b_cnt_redir;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(5), .LOAD_BUBBLES(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req_mem(dmem_req_mem),
        .dmem_resp(dmem_resp), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .rd_ex(rd_ex), .redirect_ex(redirect_ex),
        .clr_cnt(clr_cnt), .pc_en(a_pc_en), .ifid_en(a_ifid_en), .idex_en(a_idex_en),
        .exmem_en(a_exmem_en), .memwb_en(a_memwb_en), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .fetch_hold(a_fetch_hold),
        .fetch_squash(a_fetch_squash), .cnt_imem_stall(a_cnt_imem),
        .cnt_dmem_stall(a_cnt_dmem), .cnt_load_use(a_cnt_lu), .cnt_redirect(a_cnt_redir)
    );

    pipeline_hazard_ctrl #(.REG_W(5), .LOAD_BUBBLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req_mem(dmem_req_mem),
        .dmem_resp(dmem_resp), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .rd_ex(rd_ex), .redirect_ex(redirect_ex),
        .clr_cnt(clr_cnt), .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
        .exmem_en(b_exmem_en), .memwb_en(b_memwb_en), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .fetch_hold(b_fetch_hold),
        .fetch_squash(b_fetch_squash), .cnt_imem_stall(b_cnt_imem),
        .cnt_dmem_stall(b_cnt_dmem), .cnt_load_use(b_cnt_lu), .cnt_redirect(b_cnt_redir)
    );

    typedef struct {
        logic       imem, dreq, dresp;
        logic [4:0] rs1, rs2;
        logic       rs1u, rs2u, exv, exl;
        logic [4:0] rd;
        logic       redir;
        logic       e_pc, e_ifid, e_ifidfl, e_idex, e_idexfl;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic imem, dreq, dresp,
                                input logic [4:0] rs1, rs2,
                                input logic rs1u, rs2u, exv, exl,
                                input logic [4:0] rd, input logic redir,
                                input logic [4:0] exp);
        vec_t v;
        v.imem = imem; v.dreq = dreq; v.dresp = dresp;
        v.rs1 = rs1; v.rs2 = rs2; v.rs1u = rs1u; v.rs2u = rs2u;
        v.exv = exv; v.exl = exl; v.rd = rd; v.redir = redir;
        {v.e_pc, v.e_ifid, v.e_ifidfl, v.e_idex, v.e_idexfl} = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic neutral();
        imem_resp = 1'b1; dmem_req_mem = 1'b0; dmem_resp = 1'b0;
        rs1_id = '0; rs2_id = '0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; rd_ex = '0;
        redirect_ex = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        neutral();
    endtask

    task automatic lu_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs2_used_id = 1'b1;
    endtask

    task automatic dstall();
        dmem_req_mem = 1'b1; dmem_resp = 1'b0;
    endtask

    initial begin
        // fields: imem dreq dresp rs1 rs2 rs1u rs2u exv exl rd redir | pc ifid ifidfl idex idexfl
        vecs[0]  = mk(1,0,0, 0,0, 0,0, 0,0, 0, 0, 5'b11010); // normal fetch
        vecs[1]  = mk(0,0,0, 0,0, 0,0, 0,0, 0, 0, 5'b01110); // I-mem not ready: bubble
        vecs[2]  = mk(1,1,0, 0,0, 0,0, 0,0, 0, 0, 5'b00000); // D-mem stall freezes all
        vecs[3]  = mk(1,1,1, 0,0, 0,0, 0,0, 0, 0, 5'b11010); // D-mem completes
        vecs[4]  = mk(1,0,0, 0,5, 0,1, 1,1, 5, 0, 5'b00011); // load-use on rs2
        vecs[5]  = mk(1,0,0, 0,0, 0,1, 1,1, 0, 0, 5'b11010); // rd=x0: no hazard
        vecs[6]  = mk(1,0,0, 0,5, 0,0, 1,1, 5, 0, 5'b11010); // rs2 not used
        vecs[7]  = mk(1,0,0, 5,0, 1,0, 1,1, 5, 0, 5'b00011); // load-use on rs1
        vecs[8]  = mk(1,0,0, 0,5, 0,1, 0,1, 5, 0, 5'b11010); // EX bubble
        vecs[9]  = mk(1,0,0, 0,5, 0,1, 1,0, 5, 0, 5'b11010); // EX not a load
        vecs[10] = mk(1,0,0, 0,0, 0,0, 0,0, 0, 1, 5'b11111); // redirect
        vecs[11] = mk(1,0,0, 0,5, 0,1, 1,1, 5, 1, 5'b11111); // redirect beats load-use
        vecs[12] = mk(1,1,0, 0,0, 0,0, 0,0, 0, 1, 5'b00000); // redirect waits on D-mem

        // ---------------- reset ----------------
        neutral();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            check($sformatf("rst%0d pc_en", c), a_pc_en, 0);
            check($sformatf("rst%0d ifid_en", c), a_ifid_en, 0);
            check($sformatf("rst%0d idex_en", c), a_idex_en, 0);
        end
        begin_cycle(); rst = 1'b0; #1;
        check("post-rst pc_en", a_pc_en, 1);
        check("post-rst cnt_dmem", a_cnt_dmem, 0);
        check("post-rst fetch_hold", a_fetch_hold, 0);

        // ---------------- table: combinational decisions from F_RUN ----------------
        for (int i = 0; i < 13; i++) begin
            begin_cycle();
            imem_resp = vecs[i].imem; dmem_req_mem = vecs[i].dreq; dmem_resp = vecs[i].dresp;
            rs1_id = vecs[i].rs1; rs2_id = vecs[i].rs2;
            rs1_used_id = vecs[i].rs1u; rs2_used_id = vecs[i].rs2u;
            ex_valid = vecs[i].exv; ex_is_load = vecs[i].exl; rd_ex = vecs[i].rd;
            redirect_ex = vecs[i].redir;
            #1;
            check($sformatf("vec%0d pc_en", i), a_pc_en, vecs[i].e_pc);
            check($sformatf("vec%0d ifid_en", i), a_ifid_en, vecs[i].e_ifid);
            check($sformatf("vec%0d ifid_flush", i), a_ifid_flush, vecs[i].e_ifidfl);
            check($sformatf("vec%0d idex_en", i), a_idex_en, vecs[i].e_idex);
            check($sformatf("vec%0d idex_flush", i), a_idex_flush, vecs[i].e_idexfl);
            check($sformatf("vec%0d memwb_en", i), a_memwb_en, vecs[i].e_idex);
            // restore benign inputs before the edge so state is untouched
            #1 neutral();
        end

        // ---------------- early I-mem response during 4-cycle D-mem stall ----------------
        begin_cycle(); dstall(); #1;
        check("dst0 exmem_en", a_exmem_en, 0);
        check("dst0 fetch_hold", a_fetch_hold, 0);
        for (int c = 1; c < 4; c++) begin
            begin_cycle(); dstall(); imem_resp = 1'b0; #1;
            check($sformatf("dst%0d fetch_hold", c), a_fetch_hold, 1);
            check($sformatf("dst%0d ifid_en", c), a_ifid_en, 0);
            check($sformatf("dst%0d pc_en", c), a_pc_en, 0);
        end
        begin_cycle(); dmem_req_mem = 1'b1; dmem_resp = 1'b1; imem_resp = 1'b0; #1;
        check("dresp ifid_en", a_ifid_en, 1);
        check("dresp ifid_flush", a_ifid_flush, 0);
        check("dresp pc_en", a_pc_en, 1);
        begin_cycle(); #1;
        check("after dst fetch_hold", a_fetch_hold, 0);
        check("cnt_dmem_stall=4", a_cnt_dmem, 4);
        check("cnt_imem_stall=0", a_cnt_imem, 0);

        // ---------------- redirect with fetch outstanding ----------------
        begin_cycle(); imem_resp = 1'b0; redirect_ex = 1'b1; #1;
        check("redir pc_en", a_pc_en, 1);
        check("redir ifid_flush", a_ifid_flush, 1);
        check("redir idex_flush", a_idex_flush, 1);
        begin_cycle(); #1; // stale response
        check("stale fetch_squash", a_fetch_squash, 1);
        check("stale ifid_flush", a_ifid_flush, 1);
        check("stale pc_en", a_pc_en, 0);
        begin_cycle(); #1;
        check("fresh fetch_squash", a_fetch_squash, 0);
        check("fresh ifid_flush", a_ifid_flush, 0);
        check("fresh pc_en", a_pc_en, 1);
        check("cnt_redirect=1", a_cnt_redir, 1);
        check("cnt_imem_stall=1", a_cnt_imem, 1);

        // ---------------- redirect vs load-use, redirect during D-mem stall ----------------
        begin_cycle(); lu_inputs(); redirect_ex = 1'b1; #1;
        check("redir+lu dut3 pc_en", b_pc_en, 1);
        check("redir+lu dut3 ifid_flush", b_ifid_flush, 1);
        begin_cycle(); #1;
        check("post redir+lu dut3 pc_en", b_pc_en, 1);
        check("post redir+lu dut3 idex_flush", b_idex_flush, 0);
        check("redir+lu cnt_load_use", a_cnt_lu, 0);
        check("redir+lu dut3 cnt_load_use", b_cnt_lu, 0);
        check("redir+lu cnt_redirect", a_cnt_redir, 2);
        begin_cycle(); dstall(); redirect_ex = 1'b1; #1;
        check("redir in dstall pc_en", a_pc_en, 0);
        check("redir in dstall ifid_flush", a_ifid_flush, 0);
        begin_cycle(); dmem_req_mem = 1'b1; dmem_resp = 1'b1; imem_resp = 1'b0;
        redirect_ex = 1'b1; #1;
        check("redir at dresp pc_en", a_pc_en, 1);
        check("redir at dresp idex_flush", a_idex_flush, 1);
        begin_cycle(); #1;
        check("redir at dresp fetch_hold", a_fetch_hold, 0);
        check("cnt_redirect=3", a_cnt_redir, 3);

        // ---------------- load-use, 1 vs 3 bubbles ----------------
        begin_cycle(); lu_inputs(); #1;
        check("lu0 ifid_en", a_ifid_en, 0);
        check("lu0 pc_en", a_pc_en, 0);
        check("lu0 idex_flush", a_idex_flush, 1);
        check("lu0 dut3 idex_flush", b_idex_flush, 1);
        begin_cycle(); imem_resp = 1'b0; #1;
        check("lu1 pc_en (held word)", a_pc_en, 1);
        check("lu1 ifid_flush", a_ifid_flush, 0);
        check("lu1 dut3 ifid_en", b_ifid_en, 0);
        check("lu1 dut3 idex_flush", b_idex_flush, 1);
        begin_cycle(); imem_resp = 1'b0; #1;
        check("lu2 ifid_flush (no fetch)", a_ifid_flush, 1);
        check("lu2 dut3 pc_en", b_pc_en, 0);
        check("lu2 dut3 idex_flush", b_idex_flush, 1);
        begin_cycle(); imem_resp = 1'b0; #1;
        check("lu3 dut3 idex_flush", b_idex_flush, 0);
        check("lu3 dut3 pc_en", b_pc_en, 1);
        check("lu3 dut3 ifid_flush", b_ifid_flush, 0);
        begin_cycle(); #1;
        check("cnt_load_use=1", a_cnt_lu, 1);
        check("dut3 cnt_load_use=1", b_cnt_lu, 1);

        // ---------------- clear and saturation ----------------
        begin_cycle(); dstall(); imem_resp = 1'b0; clr_cnt = 1'b1; #1;
        begin_cycle(); #1;
        check("clr+inc cnt_dmem", a_cnt_dmem, 0);
        check("clr dut3 cnt_redirect", b_cnt_redir, 0);
        for (int c = 0; c < 20; c++) begin
            begin_cycle(); dstall(); imem_resp = 1'b0;
        end
        begin_cycle(); dstall(); clr_cnt = 1'b1; #1;
        check("dut3 cnt_dmem sat", b_cnt_dmem, 15);
        check("cnt_dmem=20", a_cnt_dmem, 20);
        begin_cycle(); dstall(); imem_resp = 1'b0; #1;
        check("clr+inc dut3 cnt_dmem", b_cnt_dmem, 0);
        check("pre-rst fetch_hold", a_fetch_hold, 1);

        // ---------------- reset while holding a word ----------------
        for (int c = 0; c < 2; c++) begin
            begin_cycle(); rst = 1'b1; #1;
            check($sformatf("hold-rst%0d fetch_hold", c), a_fetch_hold, 0);
            check($sformatf("hold-rst%0d pc_en", c), a_pc_en, 0);
            check($sformatf("hold-rst%0d ifid_en", c), a_ifid_en, 0);
            check($sformatf("hold-rst%0d idex_en", c), a_idex_en, 0);
        end
        begin_cycle(); rst = 1'b0; imem_resp = 1'b0; #1;
        check("hold-rst released fetch_hold", a_fetch_hold, 0);
        check("hold-rst ifid_flush (F_RUN, no resp)", a_ifid_flush, 1);
        check("hold-rst cnt_dmem", a_cnt_dmem, 0);
        check("hold-rst dut3 cnt_dmem", b_cnt_dmem, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
